wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the register file; sole driver of its write port (we, write_addr, write_data).
- Merges a single-cycle ALU result stream with a long-latency LSU/load result stream, buffering LSU results in a small FIFO.
- Keeps a 32-bit busy scoreboard of registers awaiting LSU results for the issue stage.

Parameters:
DATA_WIDTH, 64, width of result data; matches the core data type.
FIFO_DEPTH, 4, LSU result FIFO entries; power of two, at least 2.
STARVE_LIMIT, 3, consecutive ALU-won cycles with a non-empty FIFO before the FIFO is forced through.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
alu_we  input  1  ALU result valid this cycle.
alu_rd  input  5  ALU destination register index.
alu_data  input  DATA_WIDTH  ALU result.
alu_stall  output  1  ALU result this cycle not accepted; upstream holds alu_* stable.
lsu_valid  input  1  LSU result valid.
lsu_ready  output  1  FIFO can accept; transfer when lsu_valid && lsu_ready.
lsu_rd  input  5  LSU destination index.
lsu_data  input  DATA_WIDTH  LSU result.
issue_valid  input  1  an LSU op with destination issue_rd is issued this cycle.
issue_rd  input  5  destination to mark busy.
busy_mask  output  32  bit i set = x_i awaiting LSU write; bit 0 always 0.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
rf_we  output  1  register-file write enable (registered).
rf_waddr  output  5  register-file write index (registered).
rf_wdata  output  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (rst low, async): rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, FIFO empty, fifo_count=0, starve counter=0. After release: lsu_ready=1, alu_stall=0.
- lsu_ready = (fifo_count != FIFO_DEPTH). This is combinational from registered state; there is no same-cycle push-on-pop when full.
- alu_stall = (starve_cnt == STARVE_LIMIT) && FIFO non-empty.
- Per-cycle selection, result registered onto rf_* at the next edge (1-cycle latency):
  - ALU wins when alu_we && !alu_stall.
  - Otherwise the FIFO head wins if the FIFO is non-empty.
  - Otherwise rf_we=0; rf_waddr and rf_wdata hold their previous values.
- x0 handling:
  - An ALU write with rd=0 is accepted but produces rf_we=0.
  - An LSU transfer with rd=0 is accepted (handshake completes) but is not enqueued.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop occurs only when the FIFO wins arbitration.
- Starve counter:
  - Increments when ALU wins while the FIFO is non-empty.
  - Clears when the FIFO wins or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- busy_mask:
  - Set bit issue_rd on issue_valid (ignored for rd=0).
  - Clear bit rf_waddr on the cycle a FIFO-sourced write is registered.
  - Same-cycle set and clear of the same index: set wins.
- WAW between ALU and pending LSU writes to the same rd is excluded by issue logic using busy_mask; this block does not check it.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, add these ports:
  - fwd_addr_1/fwd_addr_2: inputs, 5 bits each.
  - rf_rdata_1/rf_rdata_2: inputs, DATA_WIDTH each.
  - fwd_data_1/fwd_data_2: outputs, DATA_WIDTH each.
- Forwarding rule: fwd_data_k = (rf_we && rf_waddr == fwd_addr_k && fwd_addr_k != 0) ? rf_wdata : rf_rdata_k. Purely combinational; covers the register file's write-before-edge window.
- When undefined, these ports and the logic are absent.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries and busy_mask=0x0000_0030; assert rst low -> rf_we, busy_mask and fifo_count are 0 immediately, without a clock edge.
- Single ALU write: alu_we=1, alu_rd=5, alu_data=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; alu_rd=0 -> rf_we=0.
- LSU only: issue rd=7 (busy_mask bit7=1); lsu transfer rd=7, data=0xDEAD -> cycle+1 fifo_count=1; cycle+2 rf_we=1, rf_waddr=7, rf_wdata=0xDEAD, busy_mask bit7=0.
- Full and back-pressure: hold alu_we=1 and push 4 LSU results -> lsu_ready=0 at fifo_count=4; a 5th lsu_valid is not taken and is held by the source.
- Starvation: continuous alu_we with the FIFO non-empty -> after 3 ALU wins alu_stall=1 for one cycle, FIFO head written, ALU result written the following cycle with data unchanged.
- WB_FWD_EN: rf_we=1, rf_waddr=3, rf_wdata=0x55, fwd_addr_1=3, rf_rdata_1=0x11 -> fwd_data_1=0x55; with fwd_addr_1=0 -> fwd_data_1=0x11.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU result stream with FIFO-buffered LSU results onto the register-file write port.
// Optional macro WB_FWD_EN adds combinational write-port forwarding for two read ports.
module wb_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_we,
    input  logic [4:0]                    alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    output logic                          alu_stall,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [4:0]                    lsu_rd,
    input  logic [DATA_WIDTH-1:0]         lsu_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
`ifdef WB_FWD_EN
    input  logic [4:0]                    fwd_addr_1,
    input  logic [4:0]                    fwd_addr_2,
    input  logic [DATA_WIDTH-1:0]         rf_rdata_1,
    input  logic [DATA_WIDTH-1:0]         rf_rdata_2,
    output logic [DATA_WIDTH-1:0]         fwd_data_1,
    output logic [DATA_WIDTH-1:0]         fwd_data_2,
`endif
    output logic [31:0]                   busy_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_nxt;
    logic [31:0]       busy_nxt;
    entry_t            head;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              alu_win_p0;
    logic              fifo_win_p0;
    logic              vld_p0;
    logic [4:0]        waddr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_MAX) ? v : v + 1'b1;
    endfunction

    // Stage p0: arbitration between the live ALU result and the FIFO head
    assign fifo_empty  = (fifo_count == '0);
    assign head        = mem[rd_ptr];
    assign lsu_ready   = (fifo_count != CNT_FULL);
    assign alu_stall   = (starve_cnt == SC_MAX) && !fifo_empty;
    assign alu_win_p0  = alu_we && !alu_stall;
    assign fifo_win_p0 = !alu_win_p0 && !fifo_empty;
    assign pop         = fifo_win_p0;
    // x0 loads complete the handshake but never occupy a slot
    assign push        = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    always_comb begin
        vld_p0   = 1'b0;
        waddr_p0 = rf_waddr;
        wdata_p0 = rf_wdata;
        if (alu_win_p0) begin
            vld_p0   = (alu_rd != 5'd0);
            waddr_p0 = alu_rd;
            wdata_p0 = alu_data;
        end else if (fifo_win_p0) begin
            vld_p0   = 1'b1;
            waddr_p0 = head.rd;
            wdata_p0 = head.data;
        end
    end

    always_comb begin
        starve_nxt = (fifo_win_p0 || fifo_empty) ? '0 : sat_inc(starve_cnt);
        busy_nxt   = busy_mask;
        if (fifo_win_p0) busy_nxt[head.rd] = 1'b0;
        if (issue_valid) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Stage p1: registered write port and FIFO/scoreboard state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            busy_mask  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
        end else begin
            rf_we      <= vld_p0;
            rf_waddr   <= waddr_p0;
            rf_wdata   <= wdata_p0;
            busy_mask  <= busy_nxt;
            starve_cnt <= starve_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
    end

`ifdef WB_FWD_EN
    // Covers the window where the register file has not yet absorbed the registered write
    assign fwd_data_1 = (rf_we && rf_waddr == fwd_addr_1 && fwd_addr_1 != 5'd0) ? rf_wdata : rf_rdata_1;
    assign fwd_data_2 = (rf_we && rf_waddr == fwd_addr_2 && fwd_addr_2 != 5'd0) ? rf_wdata : rf_rdata_2;
`endif

endmodule
